// File: rtl/sfx_pkg.sv
// Shared types and helpers for the two-voice sound-effect mixer.
package sfx_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    MIX  = 2'd3
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] x);
    if (x > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sfx_mixer_if.sv
// Codec/ROM-side signal bundle of the mixer; slave = mixer, master = codec + ROMs.
interface sfx_mixer_if
  import sfx_pkg::*;
#(
  parameter int LOOP_AW = 15,
  parameter int SHOT_AW = 13
);
  logic                sample_req;
  logic                loop_en;
  logic                shot_trig;
  logic [LOOP_AW-1:0]  addr_loop;
  logic [SAMPLE_W-1:0] q_loop;
  logic [SHOT_AW-1:0]  addr_shot;
  logic [SAMPLE_W-1:0] q_shot;
  logic [SAMPLE_W-1:0] audio_output;
  logic                sample_valid;
  logic                shot_busy;
  logic                overrun;

  modport master (
    output sample_req, loop_en, shot_trig, q_loop, q_shot,
    input  addr_loop, addr_shot, audio_output, sample_valid, shot_busy, overrun
  );

  modport slave (
    input  sample_req, loop_en, shot_trig, q_loop, q_shot,
    output addr_loop, addr_shot, audio_output, sample_valid, shot_busy, overrun
  );
endinterface

// File: rtl/sfx_voice.sv
// ROM read pointer for one voice: start rewinds to 0, advance steps and wraps at LEN-1.
// A looping voice is always busy; a one-shot voice drops busy after its last sample.
module sfx_voice #(
  parameter int AW   = 8,
  parameter int LEN  = 256,
  parameter int LOOP = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          advance,
  output logic [AW-1:0] ptr,
  output logic          busy
);
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          at_last;

  assign at_last = (ptr_q == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      ptr_q  <= '0;
      busy_q <= 1'b1;
    end else if (advance) begin
      if (at_last) begin
        ptr_q <= '0;
        if (LOOP == 0) busy_q <= 1'b0;
      end else begin
        ptr_q <= ptr_q + AW'(1);
      end
    end
  end

  assign ptr  = ptr_q;
  assign busy = (LOOP != 0) ? 1'b1 : busy_q;

endmodule

// File: rtl/sfx_mixer.sv
// Two-voice sequencer/mixer: per sample_req fetch both ROMs, scale, sum, saturate.
// sample_req -> sample_valid in 4 clk; requests arriving mid-frame are dropped and flagged.
module sfx_mixer
  import sfx_pkg::*;
#(
  parameter int LOOP_AW   = 15,
  parameter int LOOP_LEN  = 32768,
  parameter int SHOT_AW   = 13,
  parameter int SHOT_LEN  = 8192,
  parameter int VOL_SHIFT = 1
) (
  input logic        clk,
  input logic        resetn,
  sfx_mixer_if.slave bus
);
  state_t state_q, state_d;
  logic   in_addr, in_mix;

  logic                trig_pend;
  logic [LOOP_AW-1:0]  loop_ptr, addr_loop_q;
  logic [SHOT_AW-1:0]  shot_ptr, addr_shot_q;
  logic                loop_act, shot_busy;
  logic                loop_adv, shot_adv, shot_start;
  logic [SAMPLE_W-1:0] audio_q;
  logic                valid_q, overrun_q;

  logic signed [SAMPLE_W:0] ext_loop, ext_shot, sh_loop, sh_shot, gate_loop, gate_shot, mix_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_addr = 1'b0;
    in_mix  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.sample_req) state_d = ADDR;
      ADDR: begin
        in_addr = 1'b1;
        state_d = WAIT;
      end
      WAIT: state_d = MIX;
      MIX: begin
        in_mix  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shot_start = in_addr & trig_pend;
  assign loop_adv   = in_mix & bus.loop_en & loop_act;
  assign shot_adv   = in_mix & shot_busy;

  sfx_voice #(.AW(LOOP_AW), .LEN(LOOP_LEN), .LOOP(1)) u_voice_loop (
    .clk     (clk),
    .resetn  (resetn),
    .start   (1'b0),
    .advance (loop_adv),
    .ptr     (loop_ptr),
    .busy    (loop_act)
  );

  sfx_voice #(.AW(SHOT_AW), .LEN(SHOT_LEN), .LOOP(0)) u_voice_shot (
    .clk     (clk),
    .resetn  (resetn),
    .start   (shot_start),
    .advance (shot_adv),
    .ptr     (shot_ptr),
    .busy    (shot_busy)
  );

  // Widen to 17 b before shifting so the sum of two full-scale voices cannot wrap.
  assign ext_loop  = {bus.q_loop[SAMPLE_W-1], bus.q_loop};
  assign ext_shot  = {bus.q_shot[SAMPLE_W-1], bus.q_shot};
  assign sh_loop   = ext_loop >>> VOL_SHIFT;
  assign sh_shot   = ext_shot >>> VOL_SHIFT;
  assign gate_loop = (bus.loop_en && loop_act) ? sh_loop : 17'sd0;
  assign gate_shot = shot_busy ? sh_shot : 17'sd0;
  assign mix_sum   = gate_loop + gate_shot;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_pend   <= 1'b0;
      addr_loop_q <= '0;
      addr_shot_q <= '0;
      audio_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // A trigger landing on the ADDR edge itself stays pending for the next frame.
      trig_pend <= bus.shot_trig | (trig_pend & ~in_addr);
      valid_q   <= in_mix;
      if (bus.sample_req && (state_q != IDLE)) overrun_q <= 1'b1;
      if (in_addr) begin
        addr_loop_q <= loop_ptr;
        addr_shot_q <= trig_pend ? '0 : shot_ptr;
      end
      if (in_mix) audio_q <= sat16(mix_sum);
    end
  end

  assign bus.addr_loop    = addr_loop_q;
  assign bus.addr_shot    = addr_shot_q;
  assign bus.audio_output = audio_q;
  assign bus.sample_valid = valid_q;
  assign bus.shot_busy    = shot_busy;
  assign bus.overrun      = overrun_q;

endmodule
